// File: rtl/time_set_ctrl_if.sv
// ---------------------------------------------------------------------------
// time_set_ctrl_if
//   Groups the strobe/button inputs and the registered clock-display outputs
//   of the time-of-day set controller into one bundle.
//
//   master modport (driver side, e.g. button front end / testbench):
//     tick, btn_mode, btn_inc, btn_dec      -> out
//     hh, mm, ss, mode, blink, day_pulse    <- in
//   slave modport (time_set_ctrl):
//     tick      1 Hz one-clk timekeeping strobe
//     btn_mode  one-clk debounced pulse, advance mode
//     btn_inc   one-clk debounced pulse, increment edited field
//     btn_dec   one-clk debounced pulse, decrement edited field
//     hh/mm/ss  BCD hours/minutes/seconds
//     mode      00 RUN, 01 SET_HR, 10 SET_MIN, 11 SET_SEC
//     blink     1 = display blanks the field under edit
//     day_pulse one-clk pulse on the end-of-day rollover
// ---------------------------------------------------------------------------
interface time_set_ctrl_if;
    logic       tick;
    logic       btn_mode;
    logic       btn_inc;
    logic       btn_dec;
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
    logic [1:0] mode;
    logic       blink;
    logic       day_pulse;

    modport master (
        output tick,
        output btn_mode,
        output btn_inc,
        output btn_dec,
        input  hh,
        input  mm,
        input  ss,
        input  mode,
        input  blink,
        input  day_pulse
    );

    modport slave (
        input  tick,
        input  btn_mode,
        input  btn_inc,
        input  btn_dec,
        output hh,
        output mm,
        output ss,
        output mode,
        output blink,
        output day_pulse
    );
endinterface

// File: rtl/time_set_ctrl.sv
// ---------------------------------------------------------------------------
// time_set_ctrl
//   BCD time-of-day counter with a four-state set mode
//   (RUN -> SET_HR -> SET_MIN -> SET_SEC -> RUN on btn_mode).
//   In RUN each tick advances hh:mm:ss with BCD carries, wrapping hours after
//   HOUR_MAX and raising day_pulse for the cycle 00:00:00 first appears.
//   In a SET state timekeeping is frozen; btn_inc/btn_dec adjust only the
//   selected field with per-field wrap, and blink toggles on each tick.
//   All outputs are registered (1 clk latency).
//
//   Parameters:
//     HOUR_MAX  BCD hour value after which hours wrap to 00 (8'h01..8'h99)
//   Ports:
//     clk       system clock, rising edge
//     reset     asynchronous active-low reset
//     bus       time_set_ctrl_if.slave (strobes in, display fields out)
// ---------------------------------------------------------------------------
module time_set_ctrl #(
    parameter logic [7:0] HOUR_MAX = 8'h23
) (
    input  logic                 clk,
    input  logic                 reset,
    time_set_ctrl_if.slave       bus
);

    typedef enum logic [1:0] {
        StRun    = 2'b00,
        StSetHr  = 2'b01,
        StSetMin = 2'b10,
        StSetSec = 2'b11
    } state_e;

    localparam logic [7:0] MinSecMax = 8'h59;

    state_e     state_q, state_d;
    logic [7:0] hh_q, hh_d;
    logic [7:0] mm_q, mm_d;
    logic [7:0] ss_q, ss_d;
    logic       blink_q, blink_d;
    logic       day_pulse_q, day_pulse_d;

    // BCD increment with wrap to 00 after max. Anything at or above max also
    // wraps, so a corrupted field always falls back into the legal range.
    function automatic logic [7:0] bcd_inc(input logic [7:0] val, input logic [7:0] max);
        logic [7:0] res;
        if (val >= max) begin
            res = 8'h00;
        end else if (val[3:0] >= 4'd9) begin
            res = {val[7:4] + 4'd1, 4'd0};
        end else begin
            res = val + 8'd1;
        end
        return res;
    endfunction

    // BCD decrement with wrap to max below 00; units borrow x0 -> (x-1)9.
    function automatic logic [7:0] bcd_dec(input logic [7:0] val, input logic [7:0] max);
        logic [7:0] res;
        if (val == 8'h00 || val > max) begin
            res = max;
        end else if (val[3:0] == 4'd0) begin
            res = {val[7:4] - 4'd1, 4'd9};
        end else begin
            res = val - 8'd1;
        end
        return res;
    endfunction

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        hh_d        = hh_q;
        mm_d        = mm_q;
        ss_d        = ss_q;
        blink_d     = blink_q;
        day_pulse_d = 1'b0;

        if (bus.btn_mode) begin
            // Mode change wins over everything: coincident tick/inc/dec dropped.
            case (state_q)
                StRun:    state_d = StSetHr;
                StSetHr:  state_d = StSetMin;
                StSetMin: state_d = StSetSec;
                default:  state_d = StRun;
            endcase
            blink_d = (state_d != StRun);
        end else if (state_q == StRun) begin
            blink_d = 1'b0;
            if (bus.tick) begin
                ss_d = bcd_inc(ss_q, MinSecMax);
                if (ss_q == MinSecMax) begin
                    mm_d = bcd_inc(mm_q, MinSecMax);
                    if (mm_q == MinSecMax) begin
                        hh_d        = bcd_inc(hh_q, HOUR_MAX);
                        day_pulse_d = (hh_q == HOUR_MAX);
                    end
                end
            end
        end else begin
            if (bus.tick) begin
                blink_d = ~blink_q;
            end
            // Both buttons together cancel out.
            if (bus.btn_inc ^ bus.btn_dec) begin
                blink_d = 1'b1;
                case (state_q)
                    StSetHr: begin
                        hh_d = bus.btn_inc ? bcd_inc(hh_q, HOUR_MAX) : bcd_dec(hh_q, HOUR_MAX);
                    end
                    StSetMin: begin
                        mm_d = bus.btn_inc ? bcd_inc(mm_q, MinSecMax) : bcd_dec(mm_q, MinSecMax);
                    end
                    StSetSec: begin
                        ss_d = bus.btn_inc ? bcd_inc(ss_q, MinSecMax) : bcd_dec(ss_q, MinSecMax);
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StRun;
            hh_q        <= 8'h00;
            mm_q        <= 8'h00;
            ss_q        <= 8'h00;
            blink_q     <= 1'b0;
            day_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hh_q        <= hh_d;
            mm_q        <= mm_d;
            ss_q        <= ss_d;
            blink_q     <= blink_d;
            day_pulse_q <= day_pulse_d;
        end
    end

    assign bus.hh        = hh_q;
    assign bus.mm        = mm_q;
    assign bus.ss        = ss_q;
    assign bus.mode      = state_q;
    assign bus.blink     = blink_q;
    assign bus.day_pulse = day_pulse_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl: a vector table walked from reset plus
// hand-written sequences for BCD carries, freeze/blink and async reset.
module tb_time_set_ctrl;

    logic clk;
    logic reset;

    time_set_ctrl_if bus ();

    time_set_ctrl #(
        .HOUR_MAX (8'h23)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       tick;
        logic       bmode;
        logic       inc;
        logic       dec;
        logic [7:0] hh;
        logic [7:0] mm;
        logic [7:0] ss;
        logic [1:0] mode;
        logic       blink;
        logic       day;
    } vec_t;

    int checks;
    int errors;

    function automatic logic [27:0] pack(input logic [7:0] hh, input logic [7:0] mm,
                                         input logic [7:0] ss, input logic [1:0] mode,
                                         input logic blink, input logic day);
        return {hh, mm, ss, mode, blink, day};
    endfunction

    function automatic logic [27:0] dut_out();
        return pack(bus.hh, bus.mm, bus.ss, bus.mode, bus.blink, bus.day_pulse);
    endfunction

    task automatic check(input string name, input logic [27:0] got, input logic [27:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got hh%h mm%h ss%h mode%b blink%b day%b, expected hh%h mm%h ss%h mode%b blink%b day%b",
                     name, got[27:20], got[19:12], got[11:4], got[3:2], got[1], got[0],
                     exp[27:20], exp[19:12], exp[11:4], exp[3:2], exp[1], exp[0]);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Drive one cycle of inputs, sample 1 time unit after the rising edge.
    task automatic step(input logic t, input logic m, input logic i, input logic d);
        bus.tick     = t;
        bus.btn_mode = m;
        bus.btn_inc  = i;
        bus.btn_dec  = d;
        @(posedge clk);
        #1;
        bus.tick     = 1'b0;
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        bus.btn_dec  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    vec_t vecs[$];

    function automatic vec_t mk(input logic t, input logic m, input logic i, input logic d,
                                input logic [7:0] hh, input logic [7:0] mm, input logic [7:0] ss,
                                input logic [1:0] mode, input logic blink, input logic day);
        vec_t v;
        v.tick = t; v.bmode = m; v.inc = i; v.dec = d;
        v.hh = hh; v.mm = mm; v.ss = ss; v.mode = mode; v.blink = blink; v.day = day;
        return v;
    endfunction

    initial begin
        int bad_nibbles;
        logic [7:0] ss_hold;

        checks       = 0;
        errors       = 0;
        bus.tick     = 1'b0;
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        bus.btn_dec  = 1'b0;

        //                 t  m  i  d   hh     mm     ss     mode   bl day
        vecs.push_back(mk(1, 0, 0, 0, 8'h00, 8'h00, 8'h01, 2'b00, 0, 0)); // first tick -> 01
        vecs.push_back(mk(0, 0, 1, 0, 8'h00, 8'h00, 8'h01, 2'b00, 0, 0)); // inc ignored in RUN
        vecs.push_back(mk(0, 0, 0, 1, 8'h00, 8'h00, 8'h01, 2'b00, 0, 0)); // dec ignored in RUN
        vecs.push_back(mk(0, 1, 0, 0, 8'h00, 8'h00, 8'h01, 2'b01, 1, 0)); // -> SET_HR
        vecs.push_back(mk(1, 0, 0, 0, 8'h00, 8'h00, 8'h01, 2'b01, 0, 0)); // frozen, blink toggles
        vecs.push_back(mk(0, 0, 0, 1, 8'h23, 8'h00, 8'h01, 2'b01, 1, 0)); // 00 -> 23
        vecs.push_back(mk(0, 0, 1, 0, 8'h00, 8'h00, 8'h01, 2'b01, 1, 0)); // 23 -> 00
        vecs.push_back(mk(0, 0, 0, 1, 8'h23, 8'h00, 8'h01, 2'b01, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 8'h22, 8'h00, 8'h01, 2'b01, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 8'h21, 8'h00, 8'h01, 2'b01, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 8'h20, 8'h00, 8'h01, 2'b01, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 8'h19, 8'h00, 8'h01, 2'b01, 1, 0)); // units borrow
        vecs.push_back(mk(0, 0, 1, 0, 8'h20, 8'h00, 8'h01, 2'b01, 1, 0)); // units carry
        vecs.push_back(mk(0, 0, 1, 0, 8'h21, 8'h00, 8'h01, 2'b01, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 8'h22, 8'h00, 8'h01, 2'b01, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 8'h23, 8'h00, 8'h01, 2'b01, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 8'h23, 8'h00, 8'h01, 2'b01, 1, 0)); // inc+dec cancel
        vecs.push_back(mk(0, 1, 1, 0, 8'h23, 8'h00, 8'h01, 2'b10, 1, 0)); // mode+inc: mode only
        vecs.push_back(mk(0, 0, 0, 1, 8'h23, 8'h59, 8'h01, 2'b10, 1, 0)); // mm 00 -> 59
        vecs.push_back(mk(1, 0, 0, 0, 8'h23, 8'h59, 8'h01, 2'b10, 0, 0));
        vecs.push_back(mk(1, 0, 1, 1, 8'h23, 8'h59, 8'h01, 2'b10, 1, 0)); // cancel, blink toggles
        vecs.push_back(mk(0, 0, 1, 0, 8'h23, 8'h00, 8'h01, 2'b10, 1, 0)); // mm 59 -> 00, hh kept
        vecs.push_back(mk(0, 0, 0, 1, 8'h23, 8'h59, 8'h01, 2'b10, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 8'h23, 8'h59, 8'h01, 2'b11, 1, 0)); // -> SET_SEC
        vecs.push_back(mk(0, 0, 0, 1, 8'h23, 8'h59, 8'h00, 2'b11, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 8'h23, 8'h59, 8'h59, 2'b11, 1, 0)); // ss 00 -> 59
        vecs.push_back(mk(1, 1, 0, 0, 8'h23, 8'h59, 8'h59, 2'b00, 0, 0)); // -> RUN, tick ignored
        vecs.push_back(mk(1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 2'b00, 0, 1)); // day rollover
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 2'b00, 0, 0)); // pulse one clk only
        vecs.push_back(mk(1, 0, 0, 0, 8'h00, 8'h00, 8'h01, 2'b00, 0, 0));

        // Reset state
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("reset_state", dut_out(), pack(8'h00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Vector table
        foreach (vecs[k]) begin
            step(vecs[k].tick, vecs[k].bmode, vecs[k].inc, vecs[k].dec);
            check($sformatf("vec%0d", k), dut_out(),
                  pack(vecs[k].hh, vecs[k].mm, vecs[k].ss, vecs[k].mode, vecs[k].blink,
                       vecs[k].day));
        end

        // BCD carries: 70 ticks from 00:00:00
        do_reset();
        bad_nibbles = 0;
        for (int n = 0; n < 70; n++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            if (bus.ss[3:0] > 4'd9 || bus.ss[7:4] > 4'd9 || bus.mm[3:0] > 4'd9 ||
                bus.mm[7:4] > 4'd9 || bus.hh[3:0] > 4'd9 || bus.hh[7:4] > 4'd9) begin
                bad_nibbles++;
            end
            if (n == 9) begin
                check("ss_after_10", dut_out(), pack(8'h00, 8'h00, 8'h10, 2'b00, 1'b0, 1'b0));
            end
        end
        check("carry_70_ticks", dut_out(), pack(8'h00, 8'h01, 8'h10, 2'b00, 1'b0, 1'b0));
        check_int("bcd_nibbles_valid", bad_nibbles, 0);

        // Freeze and blink in SET_SEC: blink 1,0,1,0 with ss held
        do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("enter_set_sec", dut_out(), pack(8'h00, 8'h00, 8'h02, 2'b11, 1'b1, 1'b0));
        ss_hold = 8'h02;
        for (int n = 0; n < 3; n++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            check($sformatf("freeze_tick%0d", n), dut_out(),
                  pack(8'h00, 8'h00, ss_hold, 2'b11, n[0] ? 1'b1 : 1'b0, 1'b0));
        end

        // Leaving SET_SEC resumes counting on the next tick
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("resume_after_set", dut_out(), pack(8'h00, 8'h00, 8'h03, 2'b00, 1'b0, 1'b0));

        // Async reset mid-edit in SET_MIN at 12:34:56
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int n = 0; n < 12; n++) step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int n = 0; n < 34; n++) step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int n = 0; n < 56; n++) step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("preload_12_34_56", dut_out(), pack(8'h12, 8'h34, 8'h56, 2'b10, 1'b1, 1'b0));
        // Pending inc presented, then reset pulled between edges
        bus.btn_inc = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check("async_reset", dut_out(), pack(8'h00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        bus.btn_inc = 1'b0;
        check("reset_held", dut_out(), pack(8'h00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0));
        reset = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("first_tick_after_reset", dut_out(), pack(8'h00, 8'h00, 8'h01, 2'b00, 1'b0, 1'b0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
